riscv_muldiv: RTL and testbench
===============================

# riscv_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ALU operand-2 select. It takes operand 1 and the selected operand 2 and computes any of the eight M-extension functions. Radix-2 iteration produces one bit per cycle. A valid/ready handshake on each side lets the pipeline stall while a result is pending.

## Interface
- `WORD_LENGTH`, 32, operand/result width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous abort; drops any in-flight operation.
- `in_valid` in 1: request present.
- `in_ready` out 1: unit can accept (high only in IDLE).
- `muldiv_fn` in `MULDIV_FN`: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `op1_data` in WORD_LENGTH: rs1 value / dividend.
- `op2_data` in WORD_LENGTH: operand-2 select output / divisor.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer takes result.
- `result` out WORD_LENGTH: registered result.

## Operation
- FSM states IDLE, CALC, DONE. Reset state is IDLE.
- IDLE, `in_valid`, special case: go to DONE.
- IDLE, `in_valid`, otherwise: go to CALC.
- CALC: go to DONE when the step counter reaches WORD_LENGTH-1.
- DONE, `out_ready`: go to IDLE.
- `flush` in any state: go to IDLE next edge; `out_valid` drops and the result is discarded. `flush` has priority over a simultaneous accept or `out_ready`.
- On accept, latch:
  - function;
  - magnitudes of both operands. An operand is treated as signed for MULH/DIV/REM (both), MULHSU (op1 only), and never otherwise;
  - negate flags: product = s1^s2; quotient = s1^s2; remainder = s1.
- Multiply:
  - 2·WORD_LENGTH accumulator, shift-add, one multiplier bit per CALC cycle.
  - After the final step the product is conditionally two's-complement negated.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide:
  - Restoring division, one quotient bit per CALC cycle, WORD_LENGTH+1-bit partial remainder.
  - Quotient and remainder are fixed up on the last step.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases bypass CALC; the result is computed at accept:
  - divisor 0: quotient = all ones; remainder = op1.
  - signed overflow (op1 = 0x8000_0000, op2 = −1, DIV/REM only): quotient = op1; remainder = 0.
- `result` is written only on entry to DONE and held stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `result`=0. Internal counter and accumulators are 0.
- Accept handshake: `in_valid` && `in_ready` at edge 0.
- Normal latency: CALC occupies cycles 1..WORD_LENGTH; `out_valid` is first high in cycle WORD_LENGTH+1 (33 for 32-bit).
- Special-case latency: `out_valid` is high in cycle 1.
- Output handshake: the result transfers on an edge with `out_valid` && `out_ready`. IDLE follows, so `in_ready` is high the next cycle. There is no overlap between consecutive operations.
- `in_ready` is low throughout CALC and DONE. Inputs are sampled only at accept and may change afterwards.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).

## Structure
- Add the `MULDIV_FN` enum to `riscv_constants.sv`, next to `OP2_SEL`.
- Add a `negate`-if-flag helper function to the same package.
- One module. An optional sub-module is `riscv_muldiv_fsm` (state, counter, handshake); the datapath stays in the top.

## Test plan
- MUL 7 × 0xFFFF_FFFD (−3) -> `result` 0xFFFF_FFEB, `out_valid` in cycle 33.
- Signed-operand high products:
  - MULH 0x8000_0000 × 0x8000_0000 -> 0x4000_0000.
  - MULHSU 0xFFFF_FFFF × 0xFFFF_FFFF -> 0xFFFF_FFFF.
  - MULHU same operands -> 0xFFFF_FFFE.
- DIV 0xFFFF_FFF9 (−7) / 2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFF_FFFF and REMU 5/0 -> 5, `out_valid` in cycle 1.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
- Backpressure: `out_ready` low for 5 cycles after `out_valid` -> `result` and `out_valid` stable, `in_ready` 0. A new request accepted the cycle after the transfer completes normally.
- Aborts:
  - `flush` in cycle 10 of CALC -> IDLE next cycle, no `out_valid`; a following MUL 3×4 -> 12.
  - `rst_n` low mid-CALC -> outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_constants.sv
// Shared RV32 execute-stage constants: operand-2 select, M-extension function codes,
// multiply/divide FSM states and a small negation helper.
package riscv_constants;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP2_RS2   = 2'd0,
        OP2_IMM_I = 2'd1,
        OP2_IMM_S = 2'd2,
        OP2_PC_4  = 2'd3
    } op2_sel_t;

    // Encoding follows the funct3 field of the OP/MULDIV opcode
    typedef enum logic [2:0] {
        FN_MUL    = 3'd0,
        FN_MULH   = 3'd1,
        FN_MULHSU = 3'd2,
        FN_MULHU  = 3'd3,
        FN_DIV    = 3'd4,
        FN_DIVU   = 3'd5,
        FN_REM    = 3'd6,
        FN_REMU   = 3'd7
    } muldiv_fn_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] value,
                                                  input logic            flag);
        return flag ? -value : value;
    endfunction

endpackage

// File: rtl/riscv_muldiv_fsm.sv
// Control for the iterative multiply/divide unit: state, step counter and the
// valid/ready handshakes on both sides.
module riscv_muldiv_fsm
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = XLEN
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic special,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic accept,
    output logic calc_en,
    output logic result_we
);

    localparam int CNT_W = $clog2(WORD_LENGTH);

    muldiv_state_t    state;
    muldiv_state_t    state_next;
    logic [CNT_W-1:0] count;
    logic             last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush || state != CALC) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Result is loaded only on the edge that enters DONE; flush overrides everything
    always_comb begin
        state_next = state;
        result_we  = 1'b0;
        in_ready   = (state == IDLE);
        out_valid  = (state == DONE);
        calc_en    = (state == CALC);
        last_step  = calc_en && (count == CNT_W'(WORD_LENGTH - 1));
        accept     = in_ready && in_valid && !flush;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = special ? DONE : CALC;
                    result_we  = special;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_next = DONE;
                    result_we  = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
            result_we  = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one result bit per cycle, with divide special cases resolved at accept.
module riscv_muldiv
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = XLEN
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  muldiv_fn_t             muldiv_fn,
    input  logic [WORD_LENGTH-1:0] op1_data,
    input  logic [WORD_LENGTH-1:0] op2_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] result
);

    logic accept;
    logic calc_en;
    logic result_we;
    logic special;

    muldiv_fn_t             fn_q;
    logic [WORD_LENGTH-1:0] b_q;
    logic [WORD_LENGTH:0]   acc_hi;
    logic [WORD_LENGTH-1:0] acc_lo;
    logic                   neg_res_q;
    logic                   neg_rem_q;

    logic                   op1_signed;
    logic                   op2_signed;
    logic                   s1;
    logic                   s2;
    logic [WORD_LENGTH-1:0] op1_mag;
    logic [WORD_LENGTH-1:0] op2_mag;
    logic                   is_div;
    logic                   div_by_zero;
    logic                   overflow;
    logic [WORD_LENGTH-1:0] special_result;

    logic [WORD_LENGTH:0]     mul_sum;
    logic [WORD_LENGTH:0]     div_shift;
    logic [WORD_LENGTH:0]     div_diff;
    logic [WORD_LENGTH:0]     acc_hi_step;
    logic [WORD_LENGTH-1:0]   acc_lo_step;
    logic [2*WORD_LENGTH-1:0] product;
    logic [2*WORD_LENGTH-1:0] product_signed;
    logic [WORD_LENGTH-1:0]   quotient;
    logic [WORD_LENGTH-1:0]   remainder;
    logic [WORD_LENGTH-1:0]   calc_result;

    riscv_muldiv_fsm #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .special   (special),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .accept    (accept),
        .calc_en   (calc_en),
        .result_we (result_we)
    );

    // Operand decode at accept; special-case results never need the iterative path
    always_comb begin
        op1_signed  = (muldiv_fn inside {FN_MULH, FN_MULHSU, FN_DIV, FN_REM});
        op2_signed  = (muldiv_fn inside {FN_MULH, FN_DIV, FN_REM});
        s1          = op1_signed && op1_data[WORD_LENGTH-1];
        s2          = op2_signed && op2_data[WORD_LENGTH-1];
        op1_mag     = negate_if(op1_data, s1);
        op2_mag     = negate_if(op2_data, s2);
        is_div      = (muldiv_fn inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU});
        div_by_zero = (op2_data == '0);
        overflow    = (muldiv_fn inside {FN_DIV, FN_REM})
                      && (op1_data == {1'b1, {(WORD_LENGTH-1){1'b0}}})
                      && (op2_data == '1);
        special     = is_div && (div_by_zero || overflow);
        if (muldiv_fn inside {FN_DIV, FN_DIVU}) begin
            special_result = div_by_zero ? '1 : op1_data;
        end else begin
            special_result = div_by_zero ? op1_data : '0;
        end
    end

    // One iteration: acc_hi holds the running high product / partial remainder,
    // acc_lo the remaining multiplier bits / dividend-then-quotient bits
    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_hi[WORD_LENGTH-1:0], acc_lo[WORD_LENGTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (fn_q inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU}) begin
            if (!div_diff[WORD_LENGTH]) begin
                acc_hi_step = div_diff;
                acc_lo_step = {acc_lo[WORD_LENGTH-2:0], 1'b1};
            end else begin
                acc_hi_step = div_shift;
                acc_lo_step = {acc_lo[WORD_LENGTH-2:0], 1'b0};
            end
        end else begin
            acc_hi_step = {1'b0, mul_sum[WORD_LENGTH:1]};
            acc_lo_step = {mul_sum[0], acc_lo[WORD_LENGTH-1:1]};
        end
    end

    always_comb begin
        product        = {acc_hi_step[WORD_LENGTH-1:0], acc_lo_step};
        product_signed = neg_res_q ? -product : product;
        quotient       = negate_if(acc_lo_step, neg_res_q);
        remainder      = negate_if(acc_hi_step[WORD_LENGTH-1:0], neg_rem_q);
        case (fn_q)
            FN_MUL:                       calc_result = product_signed[WORD_LENGTH-1:0];
            FN_MULH, FN_MULHSU, FN_MULHU: calc_result = product_signed[2*WORD_LENGTH-1:WORD_LENGTH];
            FN_DIV, FN_DIVU:              calc_result = quotient;
            default:                      calc_result = remainder;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fn_q      <= FN_MUL;
            b_q       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            fn_q      <= muldiv_fn;
            b_q       <= op2_mag;
            acc_hi    <= '0;
            acc_lo    <= op1_mag;
            neg_res_q <= s1 ^ s2;
            neg_rem_q <= s1;
        end else if (calc_en) begin
            acc_hi    <= acc_hi_step;
            acc_lo    <= acc_lo_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
        end else if (result_we) begin
            result <= accept ? special_result : calc_result;
        end
    end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv: arithmetic vectors, special cases,
// backpressure, flush and asynchronous reset.
module tb_riscv_muldiv;
    import riscv_constants::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    muldiv_fn_t  muldiv_fn;
    logic [31:0] op1_data;
    logic [31:0] op2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int checks;
    int errors;

    riscv_muldiv #(
        .WORD_LENGTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .muldiv_fn (muldiv_fn),
        .op1_data  (op1_data),
        .op2_data  (op2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Presents one request, waits (bounded) for out_valid and checks latency and result
    task automatic applyStimulus(input muldiv_fn_t fn, input logic [31:0] a, input logic [31:0] b,
                                 input string tag, input logic [31:0] exp_res, input int exp_lat);
        int cycles;
        muldiv_fn = fn;
        op1_data  = a;
        op2_data  = b;
        in_valid  = 1'b1;
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1_data = $urandom();
        op2_data = $urandom();
        cycles   = 1;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        checkOutput({tag, "_result"}, result, exp_res);
        checkOutput({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic drainResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        muldiv_fn = FN_MUL;
        op1_data  = '0;
        op2_data  = '0;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(FN_MUL, 32'd7, 32'hFFFF_FFFD, "mul_neg", 32'hFFFF_FFEB, 33);
        drainResult("mul_neg");
        applyStimulus(FN_MULH, 32'h8000_0000, 32'h8000_0000, "mulh", 32'h4000_0000, 33);
        drainResult("mulh");
        applyStimulus(FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", 32'hFFFF_FFFF, 33);
        drainResult("mulhsu");
        applyStimulus(FN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", 32'hFFFF_FFFE, 33);
        drainResult("mulhu");
        applyStimulus(FN_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg", 32'hFFFF_FFFD, 33);
        drainResult("div_neg");
        applyStimulus(FN_REM, 32'hFFFF_FFF9, 32'd2, "rem_neg", 32'hFFFF_FFFF, 33);
        drainResult("rem_neg");
        applyStimulus(FN_DIVU, 32'd5, 32'd0, "divu_zero", 32'hFFFF_FFFF, 1);
        drainResult("divu_zero");
        applyStimulus(FN_REMU, 32'd5, 32'd0, "remu_zero", 32'd5, 1);
        drainResult("remu_zero");
        applyStimulus(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 32'h8000_0000, 1);
        drainResult("div_ovf");
        applyStimulus(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 32'd0, 1);
        drainResult("rem_ovf");

        // Backpressure: result must hold while the consumer stalls
        applyStimulus(FN_DIVU, 32'd100, 32'd7, "divu_bp", 32'd14, 33);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_result", result, 32'd14);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(FN_REMU, 32'd100, 32'd7, "remu_b2b", 32'd2, 33);
        drainResult("remu_b2b");

        // Flush wins over a simultaneous accept
        muldiv_fn = FN_MUL;
        op1_data  = 32'd9;
        op2_data  = 32'd9;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_accept_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_accept_out_valid", 32'(out_valid), 32'd0);

        // Flush in cycle 10 of CALC
        muldiv_fn = FN_MUL;
        op1_data  = 32'd1234;
        op2_data  = 32'd5678;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        checkOutput("pre_flush_busy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        seen_valid = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        checkOutput("flush_no_valid", 32'(seen_valid), 32'd0);
        applyStimulus(FN_MUL, 32'd3, 32'd4, "mul_after_flush", 32'd12, 33);
        drainResult("mul_after_flush");

        // Asynchronous reset in the middle of CALC
        muldiv_fn = FN_DIVU;
        op1_data  = 32'd1000;
        op2_data  = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_result", result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(FN_DIVU, 32'd100, 32'd7, "divu_after_rst", 32'd14, 33);
        drainResult("divu_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
